// File: rtl/slc3_mem_arbiter.sv
// ============================================================================
//  Module      : slc3_mem_arbiter
//  Description : SLC-3 CPU memory-port arbiter. Hands the RAM to the init
//                loader until init_done, then serves CPU reads and writes
//                with a ready handshake. IO_ADDR maps the switches on reads
//                and the hex display register on writes.
//                Optional macro SW_SYNC_EN puts a 2-flop synchronizer on SW.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slc3_mem_arbiter #(
    parameter int          ADDR_W     = 10,
    parameter int          RD_LATENCY = 2,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       init_addr,
    input  logic [15:0]       init_data,
    input  logic              init_wren,
    input  logic              init_done,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [15:0]       ram_q,
    input  logic [9:0]        SW,
    output logic [15:0]       hex_data,
    output logic              init_busy
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wr_en;
    logic [9:0]       w_sw;
    logic             w_is_io;
    logic             w_in_range;
    logic             w_unused_init_hi;

`ifdef SW_SYNC_EN
    logic [9:0] r_sw_meta;
    logic [9:0] r_sw_sync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign w_sw = r_sw_sync;
`else
    assign w_sw = SW;
`endif

    assign w_is_io          = (cpu_addr == IO_ADDR);
    assign w_in_range       = ((32'(cpu_addr) >> ADDR_W) == 32'd0);
    assign w_unused_init_hi = ^init_addr;

    // The loader drives the RAM directly while in INIT; elsewhere the CPU bus.
    // Gating with Reset keeps an aborted write from landing on the reset edge.
    always_comb begin
        if (r_state == S_INIT) begin
            ram_addr = init_addr[ADDR_W-1:0];
            ram_data = init_data;
            ram_wren = init_wren;
        end else begin
            ram_addr = cpu_addr[ADDR_W-1:0];
            ram_data = cpu_wdata;
            ram_wren = r_wr_en & ~Reset;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            ram_rden  <= 1'b0;
            cpu_rdata <= 16'h0000;
            cpu_ready <= 1'b0;
            hex_data  <= 16'h0000;
            init_busy <= 1'b1;
        end else begin
            cpu_ready <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (init_done) begin
                        r_state   <= S_IDLE;
                        init_busy <= 1'b0;
                    end
                end
                S_IDLE: begin
                    r_cnt <= '0;
                    // A write wins when oe and we are both asserted.
                    if (cpu_we) begin
                        if (w_is_io) begin
                            hex_data  <= cpu_wdata;
                            r_state   <= S_DONE;
                            cpu_ready <= 1'b1;
                        end else if (w_in_range) begin
                            r_wr_en <= 1'b1;
                            r_state <= S_WR;
                        end else begin
                            r_state   <= S_DONE;
                            cpu_ready <= 1'b1;
                        end
                    end else if (cpu_oe) begin
                        if (w_is_io) begin
                            cpu_rdata <= {6'b0, w_sw};
                            r_state   <= S_DONE;
                            cpu_ready <= 1'b1;
                        end else if (w_in_range) begin
                            ram_rden <= 1'b1;
                            r_state  <= S_RD;
                        end else begin
                            cpu_rdata <= 16'h0000;
                            r_state   <= S_DONE;
                            cpu_ready <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    r_wr_en   <= 1'b0;
                    r_state   <= S_DONE;
                    cpu_ready <= 1'b1;
                end
                S_RD: begin
                    if (r_cnt == C_CNT_LAST) begin
                        cpu_rdata <= ram_q;
                        ram_rden  <= 1'b0;
                        r_state   <= S_DONE;
                        cpu_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
